// File: rtl/xhat_block_sequencer.sv
// xhat_block_sequencer
// Tags the raw xhat sample stream with last-of-slice / last-of-block flags and
// meters the per-band d_flag stream so that the flag for band b is only released
// once the xhat stream has reached band b.
// Optional feature: define XHAT_SEQ_BLOCK_CNT_EN to add a 16-bit wrapping
// block_count output that increments once per completed block.
module xhat_block_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int BLOCK_SIZE_LOG = 8,
    parameter int BAND_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BAND_WIDTH-1:0] cfg_bands,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [DATA_WIDTH-1:0] xin_data,
    input  logic                  xin_valid,
    output logic                  xin_ready,
    output logic [DATA_WIDTH-1:0] xout_data,
    output logic                  xout_valid,
    input  logic                  xout_ready,
    output logic                  xout_last_s,
    output logic                  xout_last_b,
    input  logic                  din_data,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  dout_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  block_done
`ifdef XHAT_SEQ_BLOCK_CNT_EN
    ,
    output logic [15:0]           block_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [BLOCK_SIZE_LOG-1:0] SAMPLE_LAST = '1;

    state_t                  state;
    logic [BLOCK_SIZE_LOG-1:0] sample_cnt;
    // One bit wider than the config so the maximum band count cannot overflow
    logic [BAND_WIDTH:0]     band_cnt;
    logic [BAND_WIDTH:0]     dflag_cnt;
    logic [BAND_WIDTH-1:0]   bands_reg;

    logic running;
    logic last_s;
    logic last_b;
    logic gate;
    logic beat;
    logic dxfer;

    // Slice/block position flags and the d_flag release gate, all from registered counters
    always_comb begin
        running = (state == RUN);
        last_s  = running && (sample_cnt == SAMPLE_LAST);
        last_b  = last_s && (band_cnt == {1'b0, bands_reg});
        gate    = running && (dflag_cnt <= band_cnt) && (dflag_cnt <= {1'b0, bands_reg});
    end

    // Zero-latency stream pass-through while a block is running, fully closed otherwise
    always_comb begin
        xout_valid  = 1'b0;
        xin_ready   = 1'b0;
        xout_data   = '0;
        dout_valid  = 1'b0;
        din_ready   = 1'b0;
        dout_data   = 1'b0;
        if (running) begin
            xout_valid = xin_valid;
            xin_ready  = xout_ready;
            xout_data  = xin_data;
            dout_valid = din_valid && gate;
            din_ready  = dout_ready && gate;
            dout_data  = din_data;
        end
        beat  = xout_valid && xout_ready;
        dxfer = dout_valid && dout_ready;
    end

    assign xout_last_s = last_s;
    assign xout_last_b = last_b;
    assign cfg_ready   = (state == IDLE);
    assign block_done  = (state == DONE);

    // Block FSM with sample, band and d_flag counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            band_cnt   <= '0;
            dflag_cnt  <= '0;
            bands_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        bands_reg  <= cfg_bands;
                        sample_cnt <= '0;
                        band_cnt   <= '0;
                        dflag_cnt  <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (beat) begin
                        if (last_s) begin
                            sample_cnt <= '0;
                            band_cnt   <= band_cnt + 1'b1;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                        if (last_b) begin
                            state <= DONE;
                        end
                    end
                    if (dxfer) begin
                        dflag_cnt <= dflag_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef XHAT_SEQ_BLOCK_CNT_EN
    // Completed-block counter, wraps at 16 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            block_count <= '0;
        end else if (state == DONE) begin
            block_count <= block_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_xhat_block_sequencer.sv
// Self-checking bench for xhat_block_sequencer (BLOCK_SIZE_LOG=2, BAND_WIDTH=2).
// A block-level model (beat index within block, flags released so far) predicts
// every output each cycle; directed scenarios add literal expectations.
// Build with XHAT_SEQ_BLOCK_CNT_EN defined to also exercise block_count.
module tb_xhat_block_sequencer;

    localparam int DW = 16;
    localparam int SL = 2;
    localparam int BW = 2;
    localparam int S  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [BW-1:0] cfg_bands = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [DW-1:0] xin_data = '0;
    logic          xin_valid = 1'b0;
    logic          xin_ready;
    logic [DW-1:0] xout_data;
    logic          xout_valid;
    logic          xout_ready = 1'b0;
    logic          xout_last_s;
    logic          xout_last_b;
    logic          din_data = 1'b0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic          dout_data;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic          block_done;
`ifdef XHAT_SEQ_BLOCK_CNT_EN
    logic [15:0]   block_count;
`endif

    xhat_block_sequencer #(
        .DATA_WIDTH(DW),
        .BLOCK_SIZE_LOG(SL),
        .BAND_WIDTH(BW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_bands(cfg_bands),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .xin_data(xin_data),
        .xin_valid(xin_valid),
        .xin_ready(xin_ready),
        .xout_data(xout_data),
        .xout_valid(xout_valid),
        .xout_ready(xout_ready),
        .xout_last_s(xout_last_s),
        .xout_last_b(xout_last_b),
        .din_data(din_data),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .dout_data(dout_data),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .block_done(block_done)
`ifdef XHAT_SEQ_BLOCK_CNT_EN
        ,
        .block_count(block_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit ls;
        bit lb;
    } beat_t;

    typedef struct {
        int data;
        int blk;
        int beats;
    } flag_t;

    int     chk_cnt = 0;
    int     pass_cnt = 0;

    // Source queues and sink behaviour
    int     x_src[$];
    int     d_src[$];
    int     x_prob = 100;
    int     d_prob = 100;
    int     xr_mode = 0;
    int     dr_mode = 0;
    bit     x_take = 0;
    bit     d_take = 0;
    int     seq = 1;

    // Observation logs
    beat_t  blog[$];
    flag_t  flog[$];
    int     cyc = 0;
    int     done_cnt = 0;
    int     blk_beats = 0;
    int     last_lb_cyc = -10;
    int     last_done_cyc = -10;
    bit     cfg_after_done = 0;

    // Behavioural model state
    int     m_state = 0;
    int     m_k = 0;
    int     m_bands = 0;
    int     m_flags = 0;
    int     m_bcnt = 0;

    bit     e_run;
    bit     e_gate;
    bit     e_ls;
    bit     e_lb;
    bit     e_xv;
    bit     e_dv;
    int     e_band;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        chk_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        chk_cnt++;
        $display("[TB] FAIL %s: timed out waiting, got no event, expected one (t=%0t)", name, $time);
    endtask

    // Model prediction and comparison on every falling edge
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            m_state = 0;
            m_k     = 0;
            m_flags = 0;
            m_bands = 0;
            m_bcnt  = 0;
        end
        e_run  = (m_state == 1);
        e_band = m_k / S;
        e_gate = e_run && (m_flags <= e_band) && (m_flags <= m_bands);
        e_ls   = e_run && ((m_k % S) == S - 1);
        e_lb   = e_ls && (e_band == m_bands);
        e_xv   = e_run && xin_valid;
        e_dv   = e_gate && din_valid;

        checkOutput("cfg_ready", 32'(cfg_ready), 32'(m_state == 0));
        checkOutput("block_done", 32'(block_done), 32'(m_state == 2));
        checkOutput("xout_valid", 32'(xout_valid), 32'(e_xv));
        checkOutput("xin_ready", 32'(xin_ready), 32'(e_run && xout_ready));
        checkOutput("dout_valid", 32'(dout_valid), 32'(e_dv));
        checkOutput("din_ready", 32'(din_ready), 32'(e_gate && dout_ready));
        if (e_xv || !e_run) begin
            checkOutput("last_s", 32'(xout_last_s), 32'(e_ls));
            checkOutput("last_b", 32'(xout_last_b), 32'(e_lb));
        end
        if (e_xv) begin
            checkOutput("xout_data", 32'(xout_data), 32'(xin_data));
        end
        if (e_dv) begin
            checkOutput("dout_data", 32'(dout_data), 32'(din_data));
        end
`ifdef XHAT_SEQ_BLOCK_CNT_EN
        checkOutput("block_count", 32'(block_count), 32'(m_bcnt));
`endif

        x_take = rst && xin_valid && xin_ready;
        d_take = rst && din_valid && din_ready;

        if (!rst) begin
            blk_beats = 0;
        end else begin
            if (dout_valid && dout_ready) begin
                flog.push_back('{data: int'(dout_data), blk: done_cnt, beats: blk_beats});
            end
            if (xout_valid && xout_ready) begin
                blog.push_back('{data: int'(xout_data), ls: xout_last_s, lb: xout_last_b});
                blk_beats++;
                if (xout_last_b) last_lb_cyc = cyc;
            end
            if (cfg_ready && cyc == last_done_cyc + 1) cfg_after_done = 1;
            if (block_done) begin
                done_cnt++;
                last_done_cyc = cyc;
                blk_beats = 0;
            end

            case (m_state)
                0: begin
                    if (cfg_valid) begin
                        m_state = 1;
                        m_k     = 0;
                        m_flags = 0;
                        m_bands = int'(cfg_bands);
                    end
                end
                1: begin
                    if (e_dv && dout_ready) m_flags++;
                    if (e_xv && xout_ready) begin
                        m_k++;
                        if (m_k == S * (m_bands + 1)) m_state = 2;
                    end
                end
                default: begin
                    m_bcnt  = (m_bcnt + 1) % 65536;
                    m_state = 0;
                end
            endcase
        end
    end

    // Source and sink driver: retire accepted items, then present the next cycle's values
    always @(posedge clk) begin
        if (x_take && x_src.size() > 0) void'(x_src.pop_front());
        if (d_take && d_src.size() > 0) void'(d_src.pop_front());
        #1;
        xin_valid = (x_src.size() > 0) && ($urandom_range(99) < x_prob);
        xin_data  = (x_src.size() > 0) ? DW'(x_src[0]) : DW'($urandom);
        din_valid = (d_src.size() > 0) && ($urandom_range(99) < d_prob);
        din_data  = (d_src.size() > 0) ? d_src[0][0] : 1'($urandom);
        case (xr_mode)
            0:       xout_ready = 1'b1;
            1:       xout_ready = ~xout_ready;
            default: xout_ready = 1'($urandom);
        endcase
        dout_ready = (dr_mode == 0) ? 1'b1 : 1'($urandom);
    end

    task automatic doCfg(input int bands);
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            #1;
            if (cfg_ready) begin
                cfg_bands = BW'(bands);
                cfg_valid = 1'b1;
                @(posedge clk);
                #1;
                cfg_valid = 1'b0;
                cfg_bands = BW'($urandom);
                got = 1;
            end
        end
        if (!got) reportTimeout("cfg_handshake");
    endtask

    task automatic waitDone(input int target);
        bit got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge clk);
            if (done_cnt >= target) got = 1;
        end
        if (!got) reportTimeout("block_done");
    endtask

    task automatic pushSamples(input int n);
        for (int i = 0; i < n; i++) begin
            x_src.push_back(seq);
            seq++;
        end
    endtask

    task automatic applyStimulus(input int bands, input int nflags);
        int target;
        target = done_cnt + 1;
        pushSamples(S * (bands + 1));
        for (int i = 0; i < nflags; i++) d_src.push_back(int'($urandom_range(1)));
        doCfg(bands);
        waitDone(target);
    endtask

    task automatic checkLog(input string tag, input int n, input logic [31:0] ls_exp, input logic [31:0] lb_exp);
        logic [31:0] ls_bits;
        logic [31:0] lb_bits;
        ls_bits = '0;
        lb_bits = '0;
        checkOutput({tag, "_beats"}, 32'(blog.size()), 32'(n));
        for (int i = 0; i < blog.size() && i < 32; i++) begin
            checkOutput($sformatf("%s_data%0d", tag, i), 32'(blog[i].data), 32'(i + 1));
            ls_bits[i] = blog[i].ls;
            lb_bits[i] = blog[i].lb;
        end
        checkOutput({tag, "_last_s"}, ls_bits, ls_exp);
        checkOutput({tag, "_last_b"}, lb_bits, lb_exp);
    endtask

    task automatic resetTest();
        blog.delete();
        flog.delete();
        x_src.delete();
        d_src.delete();
        seq = 1;
    endtask

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Scenario 1: two bands, always-ready sinks
        resetTest();
        x_prob = 100; d_prob = 100; xr_mode = 0; dr_mode = 0;
        base = done_cnt;
        applyStimulus(1, 2);
        @(negedge clk);
        #1;
        checkLog("t1", 8, 32'h88, 32'h80);
        checkOutput("t1_done_after_lastb", 32'(last_done_cyc - last_lb_cyc), 32'd1);
        checkOutput("t1_done_pulses", 32'(done_cnt - base), 32'd1);
        checkOutput("t1_cfg_ready_after", 32'(cfg_after_done), 32'd1);

        // Scenario 2: d_flags queued ahead of the samples
        resetTest();
        base = done_cnt;
        d_src.push_back(1);
        d_src.push_back(0);
        d_src.push_back(1);
        doCfg(1);
        repeat (3) @(posedge clk);
        pushSamples(8);
        waitDone(base + 1);
        checkOutput("t2_flags_in_block", 32'(flog.size()), 32'd2);
        pushSamples(4);
        doCfg(0);
        waitDone(base + 2);
        checkOutput("t2_flags_total", 32'(flog.size()), 32'd3);
        if (flog.size() == 3) begin
            checkOutput("t2_f0_data", 32'(flog[0].data), 32'd1);
            checkOutput("t2_f0_beats", 32'(flog[0].beats), 32'd0);
            checkOutput("t2_f1_data", 32'(flog[1].data), 32'd0);
            checkOutput("t2_f1_beats", 32'(flog[1].beats), 32'd4);
            checkOutput("t2_f1_blk", 32'(flog[1].blk), 32'(base));
            checkOutput("t2_f2_data", 32'(flog[2].data), 32'd1);
            checkOutput("t2_f2_blk", 32'(flog[2].blk), 32'(base + 1));
            checkOutput("t2_f2_beats", 32'(flog[2].beats), 32'd0);
        end

        // Scenario 3: toggling downstream ready, single band
        resetTest();
        xr_mode = 1;
        applyStimulus(0, 1);
        checkLog("t3", 4, 32'h8, 32'h8);
        xr_mode = 0;

        // Scenario 4: maximum band count
        resetTest();
        applyStimulus(3, 4);
        checkLog("t4", 16, 32'h8888, 32'h8000);

        // Scenario 5: asynchronous reset in the middle of a block
        resetTest();
        pushSamples(8);
        doCfg(1);
        for (int i = 0; i < 100 && blog.size() < 3; i++) @(posedge clk);
        if (blog.size() < 3) reportTimeout("t5_three_beats");
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t5_cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("t5_xout_valid", 32'(xout_valid), 32'd0);
        checkOutput("t5_xin_ready", 32'(xin_ready), 32'd0);
        checkOutput("t5_last_s", 32'(xout_last_s), 32'd0);
        checkOutput("t5_last_b", 32'(xout_last_b), 32'd0);
        checkOutput("t5_dout_valid", 32'(dout_valid), 32'd0);
        checkOutput("t5_din_ready", 32'(din_ready), 32'd0);
        checkOutput("t5_block_done", 32'(block_done), 32'd0);
        x_src.delete();
        d_src.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        resetTest();
        applyStimulus(0, 1);
        checkLog("t5", 4, 32'h8, 32'h8);

`ifdef XHAT_SEQ_BLOCK_CNT_EN
        // Scenario 6: completed-block counter from reset
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("t6_count_reset", 32'(block_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int b = 0; b < 3; b++) begin
            resetTest();
            applyStimulus(0, 1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("t6_count%0d", b), 32'(block_count), 32'(b + 1));
        end
`endif

        // Randomized blocks with random valids and ready patterns
        for (int b = 0; b < 25; b++) begin
            resetTest();
            x_prob  = int'($urandom_range(30, 100));
            d_prob  = int'($urandom_range(30, 100));
            xr_mode = int'($urandom_range(2));
            dr_mode = int'($urandom_range(1));
            applyStimulus(int'($urandom_range(3)), 0);
            repeat ($urandom_range(3)) @(posedge clk);
        end
        x_prob = 100; d_prob = 100; xr_mode = 0; dr_mode = 0;
        repeat (5) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Random-phase d_flags: one per band, queued alongside each block's samples
    always @(posedge clk) begin
        if (cfg_valid && cfg_ready && x_prob != 100) begin
            for (int i = 0; i <= int'(cfg_bands); i++) d_src.push_back(int'($urandom_range(1)));
        end
    end

endmodule
